// File: rtl/rf_bank_arbiter_pkg.sv
// Shared constants and width helpers for the register-file bank arbiter.
package rf_bank_arbiter_pkg;

  localparam int DEF_NUM_RD        = 4;
  localparam int DEF_ADDR_WIDTH    = 3;
  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_MAX_WR_STREAK = 4;

  function automatic int starve_width(input int max_streak);
    return $clog2(max_streak + 1);
  endfunction

  function automatic int ptr_width(input int num_rd);
    return (num_rd > 1) ? $clog2(num_rd) : 1;
  endfunction

  localparam int STARVE_W = starve_width(DEF_MAX_WR_STREAK);
  localparam int PTR_W    = ptr_width(DEF_NUM_RD);

  // LSB of requester idx's field inside a packed address vector
  function automatic int addr_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rf_bank_arbiter_if.sv
// Requester, writeback and BRAM-side signals of one register-file bank.
interface rf_bank_arbiter_if
  import rf_bank_arbiter_pkg::*;
#(
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [NUM_RD-1:0]            rd_req;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_RD-1:0]            rd_gnt;
  logic [NUM_RD-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]        rd_data;
  logic                         wr_req;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         wr_ready;
  logic                         bram_we;
  logic [ADDR_WIDTH-1:0]        bram_addr;
  logic [DATA_WIDTH-1:0]        bram_din;
  logic [DATA_WIDTH-1:0]        bram_dout;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, bram_dout,
    output rd_gnt, rd_valid, rd_data, wr_ready, bram_we, bram_addr, bram_din
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, bram_dout,
    input  rd_gnt, rd_valid, rd_data, wr_ready, bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/rf_bank_arbiter_rr_arbiter.sv
// Pointer-based round-robin arbiter: first requester at or after ptr wins.
module rf_bank_arbiter_rr_arbiter #(
  parameter int NUM_RD = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_RD-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_RD-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < NUM_RD; k++) begin
      j = (int'(ptr) + k) % NUM_RD;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rf_bank_arbiter.sv
// Single-port bank sequencer: writes first, round-robin reads, bounded write streaks.
module rf_bank_arbiter
  import rf_bank_arbiter_pkg::*;
#(
  parameter int NUM_RD        = DEF_NUM_RD,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK
) (
  input logic               clk,
  input logic               rst_n,
  rf_bank_arbiter_if.slave  bus
);

  localparam int CNT_W = starve_width(MAX_WR_STREAK);
  localparam int IDX_W = ptr_width(NUM_RD);

  logic [CNT_W-1:0]      starve_cnt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rd_idx;
  logic [NUM_RD-1:0]     arb_req;
  logic [NUM_RD-1:0]     arb_gnt;
  logic [NUM_RD-1:0]     rd_valid_q;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic                  rd_any;
  logic                  any_rd_req;
  logic                  force_rd;
  logic                  wr_go;

  assign any_rd_req = |bus.rd_req;
  assign force_rd   = (starve_cnt == CNT_W'(MAX_WR_STREAK)) && any_rd_req;
  assign wr_go      = bus.wr_req && !force_rd;
  // a granted write owns the port, so the arbiter sees no requests that cycle
  assign arb_req    = wr_go ? '0 : bus.rd_req;

  rf_bank_arbiter_rr_arbiter #(
    .NUM_RD (NUM_RD),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  always_comb begin
    port_addr = '0;
    if (wr_go)
      port_addr = bus.wr_addr;
    else if (rd_any)
      port_addr = bus.rd_addr[addr_lsb(int'(rd_idx), ADDR_WIDTH) +: ADDR_WIDTH];
  end

  assign bus.wr_ready  = wr_go;
  assign bus.rd_gnt    = arb_gnt;
  assign bus.bram_we   = wr_go;
  assign bus.bram_addr = port_addr;
  assign bus.bram_din  = wr_go ? bus.wr_data : '0;
  assign bus.rd_data   = bus.bram_dout;
  assign bus.rd_valid  = rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= '0;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      rd_valid_q <= arb_gnt;
      if (rd_any)
        rr_ptr <= (rd_idx == IDX_W'(NUM_RD - 1)) ? '0 : rd_idx + IDX_W'(1);
      if (rd_any || !any_rd_req)
        starve_cnt <= '0;
      else if (wr_go && (starve_cnt != CNT_W'(MAX_WR_STREAK)))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/rf_bank_arbiter.md
Name: rf_bank_arbiter

Overview:
Arbitration and sequencing controller for one single-port, output-registered register-file BRAM bank (1-cycle read latency, write-first on write).
Shares the bank's single port between NUM_RD operand-collector read requesters and one writeback write port.
Writes have priority, reads are served round-robin, and a starvation counter guarantees read progress.
Sits between the operand collectors / writeback stage and the bank; the BRAM instance itself is external.

Parameters:
NUM_RD, 4, number of read requesters (>=2)
ADDR_WIDTH, 3, bank address width
DATA_WIDTH, 32, word width
MAX_WR_STREAK, 4, consecutive write grants allowed while any read is pending before one read is forced (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_req  input  NUM_RD  per-requester read request; held with address until granted
rd_addr  input  NUM_RD*ADDR_WIDTH  packed read addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_gnt  output  NUM_RD  one-hot read grant, combinational, same cycle as accepted request
rd_valid  output  NUM_RD  one-hot, high the cycle after a grant; rd_data valid for that requester
rd_data  output  DATA_WIDTH  shared read-return bus, driven directly from bram_dout
wr_req  input  1  writeback write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_ready  output  1  write accepted this cycle (transfer = wr_req & wr_ready)
bram_we  output  1  BRAM write enable
bram_addr  output  ADDR_WIDTH  BRAM address
bram_din  output  DATA_WIDTH  BRAM write data
bram_dout  input  DATA_WIDTH  BRAM registered read data

Behaviour:
- One port operation per cycle: either one write, one read, or idle. Reads and writes are never granted in the same cycle.
- force_rd = (starve_cnt == MAX_WR_STREAK) & |rd_req.
- Write grant: wr_ready = wr_req & ~force_rd. When a write is granted: bram_we=1, bram_addr=wr_addr, bram_din=wr_data, rd_gnt=0.
- Read grant: when no write is granted and |rd_req, the first requesting index at or after rr_ptr (wrapping modulo NUM_RD) is granted. bram_we=0, bram_addr=rd_addr slice of the winner.
- rr_ptr update: after a read grant to index i, rr_ptr <= (i+1) mod NUM_RD, wrapping from NUM_RD-1 to 0. It is unchanged on write or idle cycles.
- starve_cnt (width clog2(MAX_WR_STREAK+1)):
  - increments on a granted write while |rd_req;
  - clears on any read grant or when rd_req==0;
  - otherwise holds;
  - never exceeds MAX_WR_STREAK.
- rd_valid <= rd_gnt (registered). rd_data = bram_dout. rd_data is meaningful only where rd_valid is high.
- Idle (no requests): bram_we=0, bram_addr=0, bram_din=0, rd_gnt=0, wr_ready=0.
- Ordering: a read granted at cycle t returns the pre-write value even if a write to the same address is granted at t+1. A write at t followed by a read at t+1 returns the new value.
- Reset (async assert, sync release): rd_valid=0, rr_ptr=0, starve_cnt=0. The combinational outputs follow the rules above. Reset mid-operation drops any in-flight rd_valid and is never reported.
- All combinational outputs depend only on current inputs and state. There is no combinational path from bram_dout except to rd_data.

Decomposition:
- Shared package: localparams for the starve-counter width (clog2) and rr_ptr width, plus an addr-slice helper function.
- One natural sub-module: rr_arbiter (NUM_RD-wide, pointer-based round-robin, with request vector, pointer, one-hot grant and grant index).
- The starvation counter, write mux and rd_valid pipeline stay in the top.

Test Plan:
1. After reset (BRAM init mem[i]=i), rd_req=4'b0001, addr0=5 -> rd_gnt=4'b0001 same cycle; next cycle rd_valid=4'b0001, rd_data=5.
2. rd_req=4'b1111 held 6 cycles, no writes -> grants cycle through 0,1,2,3,0,1; each rd_valid one cycle later with rd_data = that requester's address.
3. wr_req addr3 data 0xDEAD together with rd_req=4'b0010 addr 3 -> wr_ready=1, rd_gnt=0, bram_we=1. Next cycle rd_gnt=4'b0010; following cycle rd_data=0xDEAD.
4. wr_req held continuously, rd_req=4'b0100, MAX_WR_STREAK=4 -> 4 write cycles, 5th cycle wr_ready=0 and rd_gnt=4'b0100. Once rd_req drops, writes resume with starve_cnt=0.
5. Grant read requester 2 at cycle t, pull rst_n low at t+0.5 -> rd_valid stays 0. After release the first read with rd_req=4'b1111 is granted to index 0.
6. No requests for 10 cycles -> bram_we=0, rd_valid=0, wr_ready=0 throughout; starve_cnt remains 0.
